count_sequence_checker: RTL

COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

---
 rtl/count_sequence_checker_if.sv | 15 +
 rtl/count_sequence_checker.sv | 90 +++++++++
 2 files changed

// File: rtl/count_sequence_checker_if.sv
// count_sequence_checker_if: count stream in, lock/error/wrap status out
interface count_sequence_checker_if #(parameter int DIGITS = 4);
    logic [DIGITS-1:0] count;
    logic              sample_en;
    logic              mode;
    logic              locked;
    logic              error;
    logic              wrap;
    logic [7:0]        err_count;
    logic [7:0]        wrap_count;
    modport master (output count, sample_en, mode,
                    input  locked, error, wrap, err_count, wrap_count);
    modport slave  (input  count, sample_en, mode,
                    output locked, error, wrap, err_count, wrap_count);
endinterface

// File: rtl/count_sequence_checker.sv
// count_sequence_checker: tracks an upstream binary/Johnson counter, locks after
// LOCK_LEN correct steps, and reports errors and wraps while locked.
module count_sequence_checker #(
    parameter int DIGITS   = 4,
    parameter int MAX      = 16,
    parameter int LOCK_LEN = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    count_sequence_checker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DIGITS-1:0] prev_q, prev_d, exp_val;
    logic [3:0]        good_q, good_d;
    logic              mode_q, mode_d, error_q, error_d, wrap_q, wrap_d, match;
    logic [7:0]        err_cnt_q, err_cnt_d, wrap_cnt_q, wrap_cnt_d;

    assign exp_val = mode_q ? {~prev_q[0], prev_q[DIGITS-1:1]}
                   : (prev_q == DIGITS'(MAX - 1)) ? '0 : prev_q + DIGITS'(1);
    assign match   = bus.count == exp_val;

    always_comb begin
        state_d    = state_q;
        prev_d     = bus.sample_en ? bus.count : prev_q;
        good_d     = good_q;
        mode_d     = bus.mode;
        error_d    = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        // a mode change restarts acquisition and outranks every other transition
        if (bus.mode != mode_q) begin
            state_d = S_IDLE;
            good_d  = '0;
        end else if (bus.sample_en) begin
            if (state_q == S_LOCK) begin
                if (match) begin
                    wrap_d     = bus.count == '0;
                    wrap_cnt_d = wrap_cnt_q + {7'd0, wrap_d};
                end else begin
                    error_d   = 1'b1;
                    err_cnt_d = err_cnt_q + {7'd0, err_cnt_q != 8'hff};
                    good_d    = '0;
                    state_d   = S_ACQ;
                end
            end else if (state_q == S_ACQ) begin
                good_d = match ? good_q + 4'd1 : '0;
                if (match && good_q == 4'(LOCK_LEN - 1)) begin
                    state_d = S_LOCK;
                    good_d  = '0;
                end
            end else begin
                good_d  = '0;
                state_d = S_ACQ;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            good_q     <= '0;
            mode_q     <= bus.mode;
            error_q    <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            mode_q     <= mode_d;
            error_q    <= error_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.locked     = state_q == S_LOCK;
    assign bus.error      = error_q;
    assign bus.wrap       = wrap_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.wrap_count = wrap_cnt_q;
endmodule
